// File: rtl/xf100_exu_wbck_arb.sv
// xf100 EXU writeback arbiter: merges NUM_CH producers onto one registered regfile write port
// and tracks in-flight destinations. Define XF100_WBCK_FIXED_PRIO_EN for fixed priority (ch0 highest).
module xf100_exu_wbck_arb #(
   parameter int NUM_CH  = 3,
   parameter int XLEN    = 32,
   parameter int RFIDX_W = 5
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [NUM_CH-1:0]          wbck_i_valid,
   output logic [NUM_CH-1:0]          wbck_o_ready,
   input  logic [NUM_CH*XLEN-1:0]     wbck_i_data,
   input  logic [NUM_CH*RFIDX_W-1:0]  wbck_i_rdidx,
   output logic                       rf_o_wr_en,
   output logic [XLEN-1:0]            rf_o_wr_data,
   output logic [RFIDX_W-1:0]         rf_o_wr_rdidx,
   input  logic                       sb_i_set_en,
   input  logic [RFIDX_W-1:0]         sb_i_set_idx,
   input  logic [RFIDX_W-1:0]         sb_i_chk_idx1,
   input  logic [RFIDX_W-1:0]         sb_i_chk_idx2,
   output logic                       sb_o_busy1,
   output logic                       sb_o_busy2,
   output logic                       sb_o_empty
);
   // Handshake: a channel transfers when valid & ready at a clk edge; ready is a
   // function of valid, so a producer holds valid/data/rdidx stable until ready.

   localparam int PTR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int SB_N  = 1 << RFIDX_W;

   logic [PTR_W-1:0]   start;
   logic [NUM_CH-1:0]  grant;
   logic               any_grant;
   logic [PTR_W-1:0]   win;
   logic [XLEN-1:0]    win_data;
   logic [RFIDX_W-1:0] win_rdidx;
   logic [SB_N-1:0]    sb, sb_nxt;

`ifdef XF100_WBCK_FIXED_PRIO_EN
   assign start = '0;
`else
   logic [PTR_W-1:0] ptr;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (any_grant)
         ptr <= (win == PTR_W'(NUM_CH - 1)) ? '0 : win + PTR_W'(1);
   end

   assign start = ptr;
`endif

   // Scan channels from the start position, wrapping modulo NUM_CH.
   always_comb begin
      int c;
      grant     = '0;
      any_grant = 1'b0;
      win       = '0;
      win_data  = '0;
      win_rdidx = '0;
      c         = 0;
      for (int i = 0; i < NUM_CH; i++) begin
         c = int'(start) + i;
         if (c >= NUM_CH) c = c - NUM_CH;
         if (!any_grant && wbck_i_valid[c]) begin
            any_grant = 1'b1;
            grant[c]  = 1'b1;
            win       = PTR_W'(c);
            win_data  = wbck_i_data[c*XLEN +: XLEN];
            win_rdidx = wbck_i_rdidx[c*RFIDX_W +: RFIDX_W];
         end
      end
   end

   assign wbck_o_ready = grant;

   // x0 writes are consumed but never reach the regfile port.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_o_wr_en    <= 1'b0;
         rf_o_wr_data  <= '0;
         rf_o_wr_rdidx <= '0;
      end else begin
         rf_o_wr_en <= any_grant && (win_rdidx != '0);
         if (any_grant && (win_rdidx != '0)) begin
            rf_o_wr_data  <= win_data;
            rf_o_wr_rdidx <= win_rdidx;
         end
      end
   end

   // Set is applied after clear so a newly dispatched producer stays pending.
   always_comb begin
      sb_nxt = sb;
      if (rf_o_wr_en)
         sb_nxt[rf_o_wr_rdidx] = 1'b0;
      if (sb_i_set_en && (sb_i_set_idx != '0))
         sb_nxt[sb_i_set_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         sb <= '0;
      else
         sb <= sb_nxt;
   end

   assign sb_o_busy1 = (sb_i_chk_idx1 != '0) && sb[sb_i_chk_idx1];
   assign sb_o_busy2 = (sb_i_chk_idx2 != '0) && sb[sb_i_chk_idx2];
   assign sb_o_empty = ~|sb;

endmodule

// File: tb/tb_xf100_exu_wbck_arb.sv
// Bench for xf100_exu_wbck_arb: directed plan items plus random traffic against a queue-based model.
module tb_xf100_exu_wbck_arb;
   localparam int N  = 3;
   localparam int XL = 32;
   localparam int RW = 5;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic [N-1:0]    wbck_i_valid = '0;
   logic [N-1:0]    wbck_o_ready;
   logic [N*XL-1:0] wbck_i_data = '0;
   logic [N*RW-1:0] wbck_i_rdidx = '0;
   logic            rf_o_wr_en;
   logic [XL-1:0]   rf_o_wr_data;
   logic [RW-1:0]   rf_o_wr_rdidx;
   logic            sb_i_set_en = 1'b0;
   logic [RW-1:0]   sb_i_set_idx = '0;
   logic [RW-1:0]   sb_i_chk_idx1 = '0;
   logic [RW-1:0]   sb_i_chk_idx2 = '0;
   logic            sb_o_busy1, sb_o_busy2, sb_o_empty;

   xf100_exu_wbck_arb #(.NUM_CH(N), .XLEN(XL), .RFIDX_W(RW)) dut (
      .clk(clk), .rst(rst),
      .wbck_i_valid(wbck_i_valid), .wbck_o_ready(wbck_o_ready),
      .wbck_i_data(wbck_i_data), .wbck_i_rdidx(wbck_i_rdidx),
      .rf_o_wr_en(rf_o_wr_en), .rf_o_wr_data(rf_o_wr_data), .rf_o_wr_rdidx(rf_o_wr_rdidx),
      .sb_i_set_en(sb_i_set_en), .sb_i_set_idx(sb_i_set_idx),
      .sb_i_chk_idx1(sb_i_chk_idx1), .sb_i_chk_idx2(sb_i_chk_idx2),
      .sb_o_busy1(sb_o_busy1), .sb_o_busy2(sb_o_busy2), .sb_o_empty(sb_o_empty)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   // Producer requests held by the bench until granted
   logic          req_v [N];
   logic [XL-1:0] req_d [N];
   logic [RW-1:0] req_i [N];

   // Reference model state
   int            m_ptr = 0;
   logic          pend [32];
   logic          cur_wr_valid = 1'b0;
   logic [RW-1:0] cur_wr_idx = '0;
   logic [XL+RW-1:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_winner();
      for (int i = 0; i < N; i++) begin
         int c;
         c = (m_ptr + i) % N;
         if (req_v[c]) return c;
      end
      return -1;
   endfunction

   task automatic model_clear();
      m_ptr = 0;
      for (int r = 0; r < 32; r++) pend[r] = 1'b0;
      cur_wr_valid = 1'b0;
      exp_q.delete();
      for (int c = 0; c < N; c++) req_v[c] = 1'b0;
   endtask

   task automatic pack();
      for (int c = 0; c < N; c++) begin
         wbck_i_valid[c]          = req_v[c];
         wbck_i_data[c*XL +: XL]  = req_d[c];
         wbck_i_rdidx[c*RW +: RW] = req_i[c];
      end
   endtask

   task automatic set_req(input int c, input logic [XL-1:0] d, input logic [RW-1:0] i);
      req_v[c] = 1'b1;
      req_d[c] = d;
      req_i[c] = i;
   endtask

   // One clock: check combinational outputs, then advance the model across the edge.
   task automatic cycle();
      int g;
      logic [N-1:0] exp_ready;
      pack();
      #1;
      g = model_winner();
      exp_ready = '0;
      if (g >= 0) exp_ready[g] = 1'b1;
      chk("ready", 64'(wbck_o_ready), 64'(exp_ready));
      chk("busy1", 64'(sb_o_busy1), 64'((sb_i_chk_idx1 != 0) && pend[sb_i_chk_idx1]));
      chk("busy2", 64'(sb_o_busy2), 64'((sb_i_chk_idx2 != 0) && pend[sb_i_chk_idx2]));
      begin
         logic e;
         e = 1'b1;
         for (int r = 0; r < 32; r++) if (pend[r]) e = 1'b0;
         chk("empty", 64'(sb_o_empty), 64'(e));
      end
      @(posedge clk);
      if (cur_wr_valid) pend[cur_wr_idx] = 1'b0;
      if (sb_i_set_en && sb_i_set_idx != 0) pend[sb_i_set_idx] = 1'b1;
      cur_wr_valid = 1'b0;
      if (g >= 0) begin
`ifdef XF100_WBCK_FIXED_PRIO_EN
         m_ptr = 0;
`else
         m_ptr = (g + 1) % N;
`endif
         if (req_i[g] != 0) begin
            cur_wr_valid = 1'b1;
            cur_wr_idx   = req_i[g];
            exp_q.push_back({req_d[g], req_i[g]});
         end
         req_v[g] = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      model_clear();
      sb_i_set_en = 1'b0;
      #1;
      chk("rst_wr_en", 64'(rf_o_wr_en), 64'd0);
      chk("rst_empty", 64'(sb_o_empty), 64'd1);
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Monitor: every regfile write must match the oldest expected write.
   always @(negedge clk) begin
      if (!rst) begin
         if (rf_o_wr_en) begin
            if (exp_q.size() == 0) begin
               chk("spurious_wr", 64'(rf_o_wr_en), 64'd0);
            end else begin
               logic [XL+RW-1:0] e;
               e = exp_q.pop_front();
               chk("wr_data", 64'(rf_o_wr_data), 64'(e[XL+RW-1:RW]));
               chk("wr_idx", 64'(rf_o_wr_rdidx), 64'(e[RW-1:0]));
            end
         end else if (exp_q.size() != 0) begin
            chk("missing_wr", 64'(rf_o_wr_en), 64'd1);
            exp_q.delete();
         end
      end
   end

   int exp_g [4];

   initial begin
      model_clear();
      for (int c = 0; c < N; c++) begin req_d[c] = '0; req_i[c] = '0; end
`ifdef XF100_WBCK_FIXED_PRIO_EN
      exp_g = '{0, 0, 0, 0};
`else
      exp_g = '{0, 1, 2, 0};
`endif
      // Reset state
      #3;
      chk("reset_wr_en", 64'(rf_o_wr_en), 64'd0);
      chk("reset_wr_data", 64'(rf_o_wr_data), 64'd0);
      chk("reset_wr_idx", 64'(rf_o_wr_rdidx), 64'd0);
      chk("reset_empty", 64'(sb_o_empty), 64'd1);
      @(negedge clk);
      rst = 1'b0;

      // Single channel 1 request
      set_req(1, 32'h100, 5'd5);
      cycle();
      cycle();
      cycle();

      // All channels continuously valid from reset
      do_reset();
      for (int k = 0; k < 4; k++) begin
         for (int c = 0; c < N; c++)
            if (!req_v[c]) set_req(c, 32'hA000 + 32'(k*4 + c), 5'(c + 1));
         pack();
         #1;
         chk("grant_seq", 64'(wbck_o_ready), 64'd1 << exp_g[k]);
         cycle();
      end
      for (int k = 0; k < 3; k++) cycle();

      // x0 write on channel 2, then check pointer wrapped to 0
      set_req(2, 32'hDEAD, 5'd0);
      cycle();
      set_req(1, 32'h11, 5'd3);
      set_req(2, 32'h22, 5'd4);
      cycle();
      cycle();
      cycle();

      // Scoreboard set then clear via writeback
      sb_i_chk_idx1 = 5'd7;
      sb_i_set_en = 1'b1; sb_i_set_idx = 5'd7;
      cycle();
      sb_i_set_en = 1'b0;
      set_req(0, 32'h77, 5'd7);
      cycle();
      cycle();
      cycle();

      // Same-cycle set and clear of index 9; index 0 never busy
      sb_i_chk_idx1 = 5'd9; sb_i_chk_idx2 = 5'd0;
      sb_i_set_en = 1'b1; sb_i_set_idx = 5'd9;
      cycle();
      sb_i_set_en = 1'b1; sb_i_set_idx = 5'd0;
      set_req(0, 32'h99, 5'd9);
      cycle();
      sb_i_set_en = 1'b1; sb_i_set_idx = 5'd9;
      cycle();
      sb_i_set_en = 1'b0;
      #1;
      chk("set_wins", 64'(sb_o_busy1), 64'd1);
      chk("x0_busy", 64'(sb_o_busy2), 64'd0);
      cycle();

      // Asynchronous reset while a write is being presented
      set_req(1, 32'h5555, 5'd12);
      pack();
      @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_wr_en", 64'(rf_o_wr_en), 64'd0);
      chk("async_empty", 64'(sb_o_empty), 64'd1);
      model_clear();
      @(negedge clk);
      rst = 1'b0;
      set_req(1, 32'h6666, 5'd13);
      set_req(2, 32'h7777, 5'd14);
      pack();
      #1;
      chk("first_after_rst", 64'(wbck_o_ready), 64'b010);
      cycle();
      cycle();
      cycle();

      // Random traffic
      for (int t = 0; t < 400; t++) begin
         for (int c = 0; c < N; c++)
            if (!req_v[c] && $urandom_range(0, 1) == 1)
               set_req(c, $urandom, 5'($urandom_range(0, 31)));
         sb_i_set_en   = ($urandom_range(0, 3) == 0);
         sb_i_set_idx  = 5'($urandom_range(0, 31));
         sb_i_chk_idx1 = ($urandom_range(0, 1) == 1) ? sb_i_set_idx : 5'($urandom_range(0, 31));
         sb_i_chk_idx2 = 5'($urandom_range(0, 31));
         cycle();
      end
      sb_i_set_en = 1'b0;
      for (int t = 0; t < 10; t++) cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout reached without completion");
      $fatal(1, "timeout");
   end
endmodule
